// File: rtl/t03_pkg.sv
// Shared types and constants for the team 03 memory/writeback sequencer.
package t03_pkg;

    // Sequencer states: accept, issue request, wait on bus, write back.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    // Default WAIT-state cycle limit for the optional bus timeout.
    localparam int TIMEOUT_CYCLES_DEF = 255;

    // x0 is hard-wired to zero, so a write to it is never issued.
    function automatic logic rd_nonzero(input logic [4:0] rd);
        return rd != 5'd0;
    endfunction

endpackage

// File: rtl/t03_bus_timer.sv
// WAIT-state watchdog: counts busy cycles and flags the one that reaches LIMIT.
// Instantiated only when T03_BUS_TIMEOUT_EN is defined.
module t03_bus_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic nRst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);
    import t03_pkg::*;

    logic [7:0] r_cnt;

    // Counter clears as WAIT is entered and advances on each busy WAIT cycle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)      r_cnt <= 8'd0;
        else if (i_clr) r_cnt <= 8'd0;
        else if (i_inc) r_cnt <= r_cnt + 8'd1;
    end

    // Expire on the LIMIT-th busy cycle so WAIT lasts exactly LIMIT cycles.
    always_comb begin
        o_expire = i_inc && (r_cnt == 8'(LIMIT - 1));
    end

endmodule

// File: rtl/t03_mem_wb_ctrl.sv
// Data-memory access and register writeback sequencer for the RV32 core.
// Shares the single register write port between same-cycle ALU results and
// delayed load results; freezes fetch while a bus transaction is outstanding.
// Optional feature: define T03_BUS_TIMEOUT_EN to abort stuck bus transactions
// after TIMEOUT_CYCLES busy WAIT cycles and raise a sticky bus_error.
module t03_mem_wb_ctrl
    import t03_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        instr_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write_req,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        freeze,
    output logic [31:0] load_data,
    output logic        rf_write_en,
    output logic [4:0]  rf_write_addr,
    output logic        bus_error
);

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_load_data;
    logic [4:0]  r_rd;
    logic        r_is_load;
    logic        w_mem_op, w_accept, w_expire;

    assign w_mem_op  = mem_read | mem_write;
    assign w_accept  = (r_state == IDLE) && instr_valid && w_mem_op;

`ifdef T03_BUS_TIMEOUT_EN
    logic r_bus_error;

    t03_bus_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .nRst    (nRst),
        .i_clr   (r_state == REQ),
        .i_inc   ((r_state == WAIT) && bus_busy),
        .o_expire(w_expire)
    );

    // Timeout flag stays set until the next reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)         r_bus_error <= 1'b0;
        else if (w_expire) r_bus_error <= 1'b1;
    end

    assign bus_error = r_bus_error;
`else
    assign w_expire  = 1'b0;
    assign bus_error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Latch the transaction at acceptance; capture read data as busy drops.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rd        <= 5'd0;
            r_is_load   <= 1'b0;
            r_load_data <= 32'd0;
        end else begin
            if (w_accept) begin
                r_addr    <= mem_addr;
                r_wdata   <= store_data;
                r_rd      <= rd_addr;
                r_is_load <= mem_read;  // read wins when both are set
            end
            if (r_state == WAIT && !bus_busy && r_is_load)
                r_load_data <= bus_rdata;
        end
    end

    // Next state; instr_valid is ignored outside IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = REQ;
            REQ:  w_next = WAIT;
            WAIT: begin
                if (!bus_busy)     w_next = WB;
                else if (w_expire) w_next = IDLE;
            end
            WB:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus request, freeze and register-write port outputs.
    always_comb begin
        bus_read      = 1'b0;
        bus_write     = 1'b0;
        freeze        = 1'b0;
        rf_write_en   = 1'b0;
        rf_write_addr = 5'd0;
        case (r_state)
            IDLE: begin
                if (instr_valid && w_mem_op) begin
                    freeze = 1'b1;
                end else if (instr_valid) begin
                    rf_write_en   = reg_write_req && rd_nonzero(rd_addr);
                    rf_write_addr = rd_addr;
                end
            end
            REQ, WAIT: begin
                freeze    = 1'b1;
                bus_read  = r_is_load;
                bus_write = !r_is_load;
            end
            WB: begin
                rf_write_en   = r_is_load && rd_nonzero(r_rd);
                rf_write_addr = r_rd;
            end
            default: ;
        endcase
    end

    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign load_data = r_load_data;

endmodule

// File: doc/t03_mem_wb_ctrl.md
# t03_mem_wb_ctrl

Multi-cycle sequencer for data-memory access and register writeback in the team 03 RV32 core. It accepts one decoded instruction per cycle from control and drives the data bus request/busy handshake for loads and stores. It freezes the PC/fetch path while a bus transaction is outstanding, latches returned load data, and emits the single register-file write strobe and address for every instruction. It sits between control/ALU and the writeback mux, sharing the one register write port between immediate (ALU/PC+4/slt) results and delayed load results.

## Interface
- TIMEOUT_CYCLES, 255: WAIT-state cycle limit before abort (used only with T03_BUS_TIMEOUT_EN); 8-bit counter, legal 1..255
- clk  in  1  system clock, all state on rising edge
- nRst  in  1  reset, asynchronous, active-low
- instr_valid  in  1  one-cycle strobe: new decoded instruction present
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- reg_write_req  in  1  instruction writes rd
- rd_addr  in  5  destination register
- mem_addr  in  32  ALU-computed address
- store_data  in  32  rs2 value for stores
- bus_rdata  in  32  data bus read data
- bus_busy  in  1  bus still processing current request
- bus_read  out  1  read request
- bus_write  out  1  write request
- bus_addr  out  32  latched request address
- bus_wdata  out  32  latched store data
- freeze  out  1  stall PC/fetch
- load_data  out  32  latched load word, feeds writeback memory_value
- rf_write_en  out  1  register-file write strobe
- rf_write_addr  out  5  register-file write address
- bus_error  out  1  sticky timeout flag

## Operation
- States: IDLE, REQ, WAIT, WB. Reset: state IDLE, every output and latch 0.
- IDLE, instr_valid, no mem op: rf_write_en = reg_write_req & (rd_addr != 0), rf_write_addr = rd_addr, both combinational same cycle; stay IDLE.
- IDLE, instr_valid & (mem_read | mem_write): latch mem_addr, store_data, rd_addr, op type; freeze = 1 combinationally this cycle; next REQ.
- mem_read & mem_write together: treat as load; store suppressed.
- REQ: assert bus_read or bus_write; next WAIT.
- WAIT: hold request, bus_addr, bus_wdata stable. On bus_busy == 0, capture bus_rdata into load_data (loads only; stores leave load_data unchanged); next WB. Request deasserts in WB.
- WB: freeze = 0. For a load, rf_write_en = 1 with the latched rd (suppressed if rd == 0). For a store, no write. Next IDLE.
- instr_valid outside IDLE is ignored; upstream is frozen.
- Async reset mid-transaction: immediate return to IDLE, requests drop, no write issued.

## Timing
- Load, busy low on first WAIT cycle: instr_valid at cycle 0, REQ at cycle 1, WAIT at cycle 2, WB/write at cycle 3.
- freeze is high for cycles 0–2.
- Each extra busy cycle adds one cycle of latency.
- Non-memory writeback takes 0 extra cycles.
- Back-to-back instr_valid in IDLE is accepted every cycle.

## Configuration
- T03_BUS_TIMEOUT_EN defined: an 8-bit counter clears on entering WAIT and increments each WAIT cycle with busy high.
  - At TIMEOUT_CYCLES the block drops the request, sets bus_error (sticky until nRst), and goes to IDLE.
  - No register write occurs and freeze clears.
- T03_BUS_TIMEOUT_EN undefined: WAIT holds indefinitely, bus_error is tied 0, and there is no counter.

## Structure
- t03_pkg holds the state enum (IDLE/REQ/WAIT/WB) and the TIMEOUT_CYCLES default constant.
- Optional sub-module t03_bus_timer (counter plus expire flag) is instantiated only under T03_BUS_TIMEOUT_EN. The FSM stays in t03_mem_wb_ctrl.

## Test plan
- Reset mid-WAIT (nRst low at cycle 2 of a load): all outputs 0 immediately, no rf_write_en afterwards.
- ALU instr, rd=5, reg_write_req=1: rf_write_en=1 and rf_write_addr=5 in the same cycle, freeze=0. Repeat with rd=0: rf_write_en=0.
- Load at addr 0x100, rd=7, busy low at once, bus_rdata=0xDEADBEEF:
  - bus_read high in cycles 1–2
  - load_data=0xDEADBEEF, rf_write_en=1, addr=7 in cycle 3
  - freeze high in cycles 0–2
- Store at 0x200, data 0x12345678, busy high 4 cycles: bus_write, addr, and wdata stay stable through busy; no rf write; freeze is released in WB.
- mem_read & mem_write together: only bus_read asserts.
- With T03_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, busy stuck high: the request drops after 4 WAIT cycles, bus_error=1 and stays 1, no write, and the next instruction is accepted.
